video_st_source: RTL and testbench

- Avalon-ST Video transmitter. Converts a raw 12-bit pixel stream (valid/ready plus start-of-frame flag) into framed Avalon-ST Video packets.
- Output feeds the scaler sink port: `sink_data`/`valid`/`ready`/`startofpacket`/`endofpacket`.
- Per frame it emits an optional control packet (width/height/interlace), then one video packet carrying exactly WIDTH*HEIGHT pixels.
- Sits between the camera/pixel front end and the scaling IP in image_streamer.

---
 rtl/video_st_source.sv | 177 +++++++++++++++++
 tb/tb_video_st_source.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_st_source.sv
// Avalon-ST Video transmitter: frames a raw pixel stream into an optional control packet plus
// one video packet per frame. Define VIDEO_ST_CTRL_PKT_EN to build the control packet.
module video_st_source #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] sauce_data,
    output logic              sauce_valid,
    input  logic              sauce_ready,
    output logic              sauce_startofpacket,
    output logic              sauce_endofpacket,
    output logic [15:0]       frame_count
);

    localparam longint unsigned Total   = longint'(WIDTH) * longint'(HEIGHT);
    localparam int unsigned     CntW    = $clog2(Total + 1);
    localparam logic [CntW-1:0] LastPix = CntW'(Total - 1);

    typedef enum logic [2:0] {StIdle, StCtrlHdr, StCtrlBody, StVidHdr, StVidBody} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              load;
    logic              in_ready_c;

`ifdef VIDEO_ST_CTRL_PKT_EN
    localparam logic [15:0] WidthW  = 16'(WIDTH);
    localparam logic [15:0] HeightW = 16'(HEIGHT);

    logic [3:0] idx_q, idx_d;
    logic [3:0] ctrl_nib;

    always_comb begin
        ctrl_nib = 4'h3;
        case (idx_q)
            4'd0:    ctrl_nib = WidthW[15:12];
            4'd1:    ctrl_nib = WidthW[11:8];
            4'd2:    ctrl_nib = WidthW[7:4];
            4'd3:    ctrl_nib = WidthW[3:0];
            4'd4:    ctrl_nib = HeightW[15:12];
            4'd5:    ctrl_nib = HeightW[11:8];
            4'd6:    ctrl_nib = HeightW[7:4];
            4'd7:    ctrl_nib = HeightW[3:0];
            default: ctrl_nib = 4'h3;  // interlace nibble: progressive
        endcase
    end
`endif

    // Output register only advances when empty or being drained this cycle.
    assign load = !valid_q || sauce_ready;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        valid_d       = valid_q;
        sop_d         = sop_q;
        eop_d         = eop_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        in_ready_c    = 1'b0;
`ifdef VIDEO_ST_CTRL_PKT_EN
        idx_d         = idx_q;
`endif
        if (load) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end

        case (state_q)
            StIdle: begin
                // Non-sof pixels are swallowed to resync; the sof pixel waits for VID_BODY.
                in_ready_c = !(in_valid && in_sof);
                if (in_valid && in_sof) begin
`ifdef VIDEO_ST_CTRL_PKT_EN
                    state_d = StCtrlHdr;
`else
                    state_d = StVidHdr;
`endif
                end
            end
`ifdef VIDEO_ST_CTRL_PKT_EN
            StCtrlHdr: begin
                if (load) begin
                    data_d  = DATA_W'(4'hF);
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    idx_d   = 4'd0;
                    state_d = StCtrlBody;
                end
            end
            StCtrlBody: begin
                if (load) begin
                    data_d  = DATA_W'(ctrl_nib);
                    valid_d = 1'b1;
                    eop_d   = (idx_q == 4'd8);
                    if (idx_q == 4'd8) begin
                        state_d = StVidHdr;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`endif
            StVidHdr: begin
                if (load) begin
                    data_d  = '0;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StVidBody;
                end
            end
            StVidBody: begin
                in_ready_c = load;
                if (load && in_valid) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                    if (cnt_q == LastPix) begin
                        eop_d         = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q       <= StIdle;
            data_q        <= '0;
            valid_q       <= 1'b0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
            cnt_q         <= '0;
            frame_count_q <= '0;
`ifdef VIDEO_ST_CTRL_PKT_EN
            idx_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
`ifdef VIDEO_ST_CTRL_PKT_EN
            idx_q         <= idx_d;
`endif
        end
    end

    assign in_ready            = in_ready_c && !reset_reset;
    assign sauce_data          = data_q;
    assign sauce_valid         = valid_q;
    assign sauce_startofpacket = sop_q;
    assign sauce_endofpacket   = eop_q;
    assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_video_st_source.sv
// Self-checking bench for video_st_source (WIDTH=4, HEIGHT=2); follows VIDEO_ST_CTRL_PKT_EN.
module tb_video_st_source;

    localparam int DW   = 12;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset_reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [DW-1:0] sauce_data;
    logic          sauce_valid;
    logic          sauce_ready;
    logic          sauce_sop;
    logic          sauce_eop;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    video_st_source #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk_clk             (clk),
        .reset_reset         (reset_reset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_sof              (in_sof),
        .in_ready            (in_ready),
        .sauce_data          (sauce_data),
        .sauce_valid         (sauce_valid),
        .sauce_ready         (sauce_ready),
        .sauce_startofpacket (sauce_sop),
        .sauce_endofpacket   (sauce_eop),
        .frame_count         (frame_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        logic [DW-1:0] base;
        int            junk;
        bit            bp;
        logic [15:0]   exp_fc;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[4];
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    bp_mode = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        $display("FAIL %s: got timeout, want completion", name);
    endfunction

    function automatic void push_frame(logic [DW-1:0] base);
        logic [39:0] ctrl;
        ctrl = {16'(W), 16'(H), 4'h3};
`ifdef VIDEO_ST_CTRL_PKT_EN
        sb.push_back('{data: DW'(4'hF), sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < 9; i++)
            sb.push_back('{data: DW'(ctrl[4*(9-i)-1 -: 4]), sop: 1'b0, eop: (i == 8)});
`endif
        sb.push_back('{data: '0, sop: 1'b1, eop: 1'b0});
        for (int i = 0; i < NPIX; i++)
            sb.push_back('{data: base + DW'(i), sop: 1'b0, eop: (i == NPIX - 1)});
    endfunction

    task automatic drive_pix(input logic [DW-1:0] d, input logic sof);
        logic acc;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                #1;
                return;
            end
        end
        fail_now("pixel_accept");
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int junk, input int npix);
        for (int j = 0; j < junk; j++) drive_pix(DW'(12'h0A0 + j), 1'b0);
        drive_pix(base, 1'b1);
        for (int i = 1; i < npix; i++) drive_pix(base + DW'(i), 1'b0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) fail_now("drain");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{base: 12'h101, junk: 0, bp: 1'b0, exp_fc: 16'd1};
        vecs[1] = '{base: 12'h101, junk: 0, bp: 1'b1, exp_fc: 16'd2};
        vecs[2] = '{base: 12'h200, junk: 3, bp: 1'b0, exp_fc: 16'd3};
        vecs[3] = '{base: 12'h300, junk: 2, bp: 1'b1, exp_fc: 16'd4};

        reset_reset = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        sauce_ready = 1'b1;

        fork
            begin : ready_drv
                int pat[4] = '{1, 0, 0, 1};
                int k = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (bp_mode) begin
                        sauce_ready = pat[k][0];
                        k = (k + 1) % 4;
                    end else begin
                        sauce_ready = 1'b1;
                    end
                end
            end
            begin : monitor
                logic  stall_prev = 1'b0;
                beat_t held;
                beat_t exp;
                forever begin
                    @(negedge clk);
                    if (reset_reset) begin
                        stall_prev = 1'b0;
                    end else begin
                        if (stall_prev) begin
                            chk("held_beat", {sauce_valid, sauce_data, sauce_sop, sauce_eop},
                                {1'b1, held});
                        end
                        if (sauce_valid && !sauce_ready && !sauce_eop)
                            chk("in_ready_stall", in_ready, 0);
                        if (sauce_valid && sauce_ready) begin
                            if (sb.size() == 0) begin
                                chk("extra_beat", {sauce_data, sauce_sop, sauce_eop}, 32'hFFFF_FFFF);
                            end else begin
                                exp = sb.pop_front();
                                chk("beat", {sauce_data, sauce_sop, sauce_eop}, exp);
                            end
                        end
                        stall_prev = sauce_valid && !sauce_ready;
                        held       = '{data: sauce_data, sop: sauce_sop, eop: sauce_eop};
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", sauce_valid, 0);
        chk("rst_sop", sauce_sop, 0);
        chk("rst_eop", sauce_eop, 0);
        chk("rst_data", sauce_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1 reset_reset = 1'b0;

        for (int v = 0; v < 4; v++) begin
            bp_mode = vecs[v].bp;
            push_frame(vecs[v].base);
            send_frame(vecs[v].base, vecs[v].junk, NPIX);
            wait_drain();
            bp_mode = 1'b0;
            chk($sformatf("frame_count_v%0d", v), frame_count, vecs[v].exp_fc);
        end

        // Abandon a packet after 5 video pixels.
        push_frame(12'h400);
        send_frame(12'h400, 0, 5);
        reset_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_valid", sauce_valid, 0);
        chk("midrst_frame_count", frame_count, 0);
        sb.delete();
        @(posedge clk);
        #1 reset_reset = 1'b0;
        push_frame(12'h410);
        send_frame(12'h410, 0, NPIX);
        wait_drain();
        chk("post_rst_frame_count", frame_count, 1);

        // frame_count wraps from 0xFFFF.
        @(posedge clk);
        #1 force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        push_frame(12'h500);
        send_frame(12'h500, 0, NPIX);
        wait_drain();
        chk("wrap_frame_count", frame_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
